// File: rtl/rv_pkg.sv
// Shared RV32 datapath constants, ALU opcode encodings and the funct3 -> ALU opcode map
// used by the ID/EX issue stage.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branches compare by subtracting and loads add base+offset, whatever funct3 says.
  function automatic logic [2:0] alu_op_map(input logic [2:0] funct3,
                                            input logic       funct7_5,
                                            input logic       use_imm,
                                            input logic       is_branch,
                                            input logic       is_load);
    logic [2:0] op;
    op = ALU_ADD;
    if (is_branch) begin
      op = ALU_SUB;
    end else if (is_load) begin
      op = ALU_ADD;
    end else begin
      case (funct3)
        F3_ADD:  op = (funct7_5 && !use_imm) ? ALU_SUB : ALU_ADD;
        F3_SLL:  op = ALU_SLL;
        F3_SLT:  op = ALU_SUB;
        F3_SLTU: op = ALU_SUB;
        F3_XOR:  op = ALU_XOR;
        F3_SR:   op = ALU_SRL;
        F3_OR:   op = ALU_OR;
        F3_AND:  op = ALU_AND;
        default: op = ALU_ADD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass mux: picks EX/MEM, then MEM/WB, then the registered regfile value.
// x0 always reads zero; FWD_EN=0 disables both bypass paths.
module fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [REG_AW-1:0] src,
  input  logic [XLEN-1:0]   reg_data,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              mwb_wr_en,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_data,
  output logic [XLEN-1:0]   operand
);

  logic exm_hit;
  logic mwb_hit;

  assign exm_hit = FWD_EN && exm_wr_en && (exm_rd == src);
  assign mwb_hit = FWD_EN && mwb_wr_en && (mwb_rd == src);

  // The younger writer in EX/MEM wins over MEM/WB.
  always_comb begin
    operand = reg_data;
    if (src == '0) begin
      operand = '0;
    end else if (exm_hit) begin
      operand = exm_data;
    end else if (mwb_hit) begin
      operand = mwb_data;
    end
  end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX issue stage feeding the 32-bit ALU: registers one decoded instruction, maps the ALU
// opcode, forwards operands and interlocks hazards. Define ID_EX_FORWARD_EN to enable bypassing.
module id_ex_issue #(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int REG_AW = rv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7_5,
  input  logic              in_is_branch,
  input  logic              in_is_load,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              mwb_wr_en,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   A,
  output logic [XLEN-1:0]   B,
  output logic [2:0]        opcode,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_is_load,
  output logic [2:0]        out_funct3
);
  import rv_pkg::*;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic              valid_q;
  logic [REG_AW-1:0] rs1_addr_q;
  logic [REG_AW-1:0] rs2_addr_q;
  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   rs2_data_q;
  logic [XLEN-1:0]   imm_q;
  logic              b_imm_q;
  logic [2:0]        op_q;
  logic [2:0]        funct3_q;
  logic [REG_AW-1:0] rd_q;
  logic              load_q;

  logic              rs2_used;
  logic              held_hit;
  logic              stall;
  logic              capture;
  logic [XLEN-1:0]   rs1_fwd;
  logic [XLEN-1:0]   rs2_fwd;

  assign rs2_used = ~in_use_imm | in_is_branch;

  // Does the instruction currently held here write a register the incoming one reads?
  assign held_hit = valid_q && (rd_q != '0) &&
                    ((rd_q == in_rs1_addr) || (rs2_used && (rd_q == in_rs2_addr)));

`ifdef ID_EX_FORWARD_EN
  assign stall = held_hit && load_q;
`else
  // Without bypass the reader waits until the writer has left EX/MEM; MEM/WB is covered
  // by the write-before-read regfile.
  logic exm_hit;
  assign exm_hit = exm_wr_en && (exm_rd != '0) &&
                   ((exm_rd == in_rs1_addr) || (rs2_used && (exm_rd == in_rs2_addr)));
  assign stall   = held_hit || exm_hit;
`endif

  assign in_ready = (~valid_q | out_ready) & ~stall & ~flush;
  assign capture  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      b_imm_q    <= 1'b0;
      op_q       <= ALU_ADD;
      funct3_q   <= 3'b000;
      rd_q       <= '0;
      load_q     <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q    <= 1'b1;
      rs1_addr_q <= in_rs1_addr;
      rs2_addr_q <= in_rs2_addr;
      rs1_data_q <= in_rs1_data;
      rs2_data_q <= in_rs2_data;
      imm_q      <= in_imm;
      b_imm_q    <= in_use_imm & ~in_is_branch;
      op_q       <= alu_op_map(in_funct3, in_funct7_5, in_use_imm, in_is_branch, in_is_load);
      funct3_q   <= in_funct3;
      rd_q       <= in_rd_addr;
      load_q     <= in_is_load;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Bypass sits after the register so a held instruction keeps picking up late writers.
  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_rs1 (
    .src       (rs1_addr_q),
    .reg_data  (rs1_data_q),
    .exm_wr_en (exm_wr_en),
    .exm_rd    (exm_rd),
    .exm_data  (exm_data),
    .mwb_wr_en (mwb_wr_en),
    .mwb_rd    (mwb_rd),
    .mwb_data  (mwb_data),
    .operand   (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_rs2 (
    .src       (rs2_addr_q),
    .reg_data  (rs2_data_q),
    .exm_wr_en (exm_wr_en),
    .exm_rd    (exm_rd),
    .exm_data  (exm_data),
    .mwb_wr_en (mwb_wr_en),
    .mwb_rd    (mwb_rd),
    .mwb_data  (mwb_data),
    .operand   (rs2_fwd)
  );

  assign out_valid    = valid_q;
  assign A            = rs1_fwd;
  assign B            = b_imm_q ? imm_q : rs2_fwd;
  assign opcode       = op_q;
  assign out_rs2_data = rs2_fwd;
  assign out_rd_addr  = rd_q;
  assign out_is_load  = load_q;
  assign out_funct3   = funct3_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed testbench for id_ex_issue: opcode map, handshake, hold/flush, hazards and bypass.
// Expectations follow ID_EX_FORWARD_EN the same way the design does.
module tb_id_ex_issue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm, in_funct7_5, in_is_branch, in_is_load;
  logic [2:0]  in_funct3;
  logic        exm_wr_en, mwb_wr_en;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_data, mwb_data;
  logic        out_valid, out_ready, out_is_load;
  logic [31:0] A, B, out_rs2_data;
  logic [2:0]  opcode, out_funct3;
  logic [4:0]  out_rd_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_funct3(in_funct3),
    .in_funct7_5(in_funct7_5), .in_is_branch(in_is_branch), .in_is_load(in_is_load),
    .in_rd_addr(in_rd_addr),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B), .opcode(opcode),
    .out_rs2_data(out_rs2_data), .out_rd_addr(out_rd_addr),
    .out_is_load(out_is_load), .out_funct3(out_funct3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] imm, input logic use_imm,
                                input logic [2:0] f3, input logic f7,
                                input logic br, input logic ld, input logic [4:0] rd);
    in_valid     = 1'b1;
    in_rs1_addr  = rs1;
    in_rs2_addr  = rs2;
    in_rs1_data  = d1;
    in_rs2_data  = d2;
    in_imm       = imm;
    in_use_imm   = use_imm;
    in_funct3    = f3;
    in_funct7_5  = f7;
    in_is_branch = br;
    in_is_load   = ld;
    in_rd_addr   = rd;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    exm_wr_en = 1'b0; exm_rd = 5'd0; exm_data = 32'd0;
    mwb_wr_en = 1'b0; mwb_rd = 5'd0; mwb_data = 32'd0;
    apply_stimulus(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);
    in_valid = 1'b0;
    step();
    step();
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_opcode", 32'(opcode), 32'd0);
    check_output("rst_rd", 32'(out_rd_addr), 32'd0);
    check_output("rst_A", A, 32'd0);
    rst = 1'b0;
    #1;
    check_output("rst_in_ready", 32'(in_ready), 32'd1);

    // add x3,x1,x2
    apply_stimulus(5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd3);
    #1;
    check_output("add_in_ready", 32'(in_ready), 32'd1);
    step();
    check_output("add_valid", 32'(out_valid), 32'd1);
    check_output("add_A", A, 32'd5);
    check_output("add_B", B, 32'd7);
    check_output("add_op", 32'(opcode), 32'd0);
    check_output("add_rd", 32'(out_rd_addr), 32'd3);

    // sub x7,x5,x6
    apply_stimulus(5'd5, 5'd6, 32'd20, 32'd8, 32'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd7);
    step();
    check_output("sub_op", 32'(opcode), 32'b010);
    check_output("sub_A", A, 32'd20);
    check_output("sub_B", B, 32'd8);

    // addi x9,x8,-1 (imm bit 30 set must not turn it into sub)
    apply_stimulus(5'd8, 5'd31, 32'd1, 32'd9, 32'hFFFF_FFFF, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 5'd9);
    step();
    check_output("addi_op", 32'(opcode), 32'b000);
    check_output("addi_B", B, 32'hFFFF_FFFF);
    check_output("addi_A", A, 32'd1);

    // sra x18 issues as srl
    apply_stimulus(5'd16, 5'd17, 32'd64, 32'd2, 32'd0, 1'b0, 3'b101, 1'b1, 1'b0, 1'b0, 5'd18);
    step();
    check_output("sra_op", 32'(opcode), 32'b101);

    // bne x19,x21 forces sub, B is rs2
    apply_stimulus(5'd19, 5'd21, 32'd0, 32'h33, 32'd0, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 5'd0);
    step();
    check_output("br_op", 32'(opcode), 32'b010);
    check_output("br_B", B, 32'h33);

    // lw x4,4(x10)
    apply_stimulus(5'd10, 5'd0, 32'd100, 32'd0, 32'd4, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 5'd4);
    step();
    check_output("lw_op", 32'(opcode), 32'b000);
    check_output("lw_A", A, 32'd100);
    check_output("lw_B", B, 32'd4);
    check_output("lw_is_load", 32'(out_is_load), 32'd1);
    check_output("lw_rd", 32'(out_rd_addr), 32'd4);
    check_output("lw_funct3", 32'(out_funct3), 32'b010);

    // add x5,x4,x6 right behind the load
    apply_stimulus(5'd4, 5'd6, 32'd0, 32'd3, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd5);
    #1;
    check_output("lu_stall", 32'(in_ready), 32'd0);
    step();
    check_output("lu_bubble", 32'(out_valid), 32'd0);
`ifdef ID_EX_FORWARD_EN
    mwb_wr_en = 1'b1; mwb_rd = 5'd4; mwb_data = 32'd55;
    #1;
    check_output("lu_release", 32'(in_ready), 32'd1);
`else
    exm_wr_en = 1'b1; exm_rd = 5'd4; exm_data = 32'd100;
    #1;
    check_output("lu_exm_stall", 32'(in_ready), 32'd0);
    step();
    check_output("lu_bubble2", 32'(out_valid), 32'd0);
    exm_wr_en = 1'b0;
    mwb_wr_en = 1'b1; mwb_rd = 5'd4; mwb_data = 32'd55;
    in_rs1_data = 32'd55;
    #1;
    check_output("lu_release", 32'(in_ready), 32'd1);
`endif
    step();
    check_output("lu_valid", 32'(out_valid), 32'd1);
    check_output("lu_A", A, 32'd55);
    check_output("lu_B", B, 32'd3);
    mwb_wr_en = 1'b0;

    // add x15,x1,x2 then bypass probes on the held operands
    apply_stimulus(5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd15);
    step();
    in_valid = 1'b0;
    exm_wr_en = 1'b1; exm_rd = 5'd1; exm_data = 32'hAA;
    mwb_wr_en = 1'b1; mwb_rd = 5'd1; mwb_data = 32'hBB;
    #1;
`ifdef ID_EX_FORWARD_EN
    check_output("fwd_exm_prio", A, 32'hAA);
    mwb_rd = 5'd2; mwb_data = 32'hCC;
    #1;
    check_output("fwd_mwb_B", B, 32'hCC);
    check_output("fwd_mwb_rs2", out_rs2_data, 32'hCC);
    exm_wr_en = 1'b0; mwb_rd = 5'd1; mwb_data = 32'hBB;
    #1;
    check_output("fwd_mwb_A", A, 32'hBB);
`else
    check_output("nofwd_A", A, 32'd1);
    check_output("nofwd_B", B, 32'd2);
`endif
    exm_wr_en = 1'b0; mwb_wr_en = 1'b0;

    // back-to-back dependent add x16,x15,x6
    apply_stimulus(5'd15, 5'd6, 32'd0, 32'd3, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd16);
    #1;
`ifdef ID_EX_FORWARD_EN
    check_output("dep_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    exm_wr_en = 1'b1; exm_rd = 5'd15; exm_data = 32'h99;
    #1;
`else
    check_output("dep_stall", 32'(in_ready), 32'd0);
    step();
    check_output("dep_bubble", 32'(out_valid), 32'd0);
    exm_wr_en = 1'b1; exm_rd = 5'd15; exm_data = 32'h99;
    #1;
    check_output("dep_exm_stall", 32'(in_ready), 32'd0);
    step();
    check_output("dep_bubble2", 32'(out_valid), 32'd0);
    exm_wr_en = 1'b0;
    in_rs1_data = 32'h99;
    #1;
    check_output("dep_release", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
`endif
    check_output("dep_valid", 32'(out_valid), 32'd1);
    check_output("dep_A", A, 32'h99);
    exm_wr_en = 1'b0;

    // x0 source with an EX/MEM writer targeting x0
    apply_stimulus(5'd0, 5'd0, 32'd123, 32'd456, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd17);
    exm_wr_en = 1'b1; exm_rd = 5'd0; exm_data = 32'd77;
    #1;
    check_output("x0_in_ready", 32'(in_ready), 32'd1);
    step();
    check_output("x0_A", A, 32'd0);
    check_output("x0_B", B, 32'd0);
    exm_wr_en = 1'b0;

    // and x14,x12,x13, then back-pressure for three cycles
    apply_stimulus(5'd12, 5'd13, 32'h1234, 32'h0F0F, 32'd0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 5'd14);
    step();
    check_output("and_op", 32'(opcode), 32'b111);
    out_ready = 1'b0;
    apply_stimulus(5'd20, 5'd21, 32'h500, 32'h600, 32'd0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 5'd22);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output("hold_in_ready", 32'(in_ready), 32'd0);
      step();
      check_output("hold_valid", 32'(out_valid), 32'd1);
      check_output("hold_A", A, 32'h1234);
      check_output("hold_B", B, 32'h0F0F);
      check_output("hold_op", 32'(opcode), 32'b111);
    end
    flush = 1'b1;
    #1;
    check_output("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    check_output("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; out_ready = 1'b1;
    #1;
    check_output("represent_in_ready", 32'(in_ready), 32'd1);
    step();
    check_output("represent_valid", 32'(out_valid), 32'd1);
    check_output("represent_A", A, 32'h500);
    check_output("represent_B", B, 32'h600);
    check_output("represent_op", 32'(opcode), 32'b110);

    // drain with nothing offered
    in_valid = 1'b0;
    step();
    check_output("drain_valid", 32'(out_valid), 32'd0);
    check_output("drain_in_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
